// File: rtl/spi_dc_tx_sched.sv
// spi_dc_tx_sched: round-robin scheduler sharing an SPI slave transmit path, plus receive status counters
module spi_dc_tx_sched #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int START_LEN = 2,
  parameter int TMO = 4096,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    slv_tx_en,
  output logic                    slv_rx_en,
  output logic                    slv_start,
  output logic [DW-1:0]           slv_din,
  input  logic                    slv_sed_qvld,
  input  logic                    slv_rec_qvld,
  input  logic                    slv_err_one,
  input  logic                    slv_err_mul,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    done,
  output logic                    timeout,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        rx_cnt,
  output logic [CNT_W-1:0]        err1_cnt,
  output logic [CNT_W-1:0]        err2_cnt
);
  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TMO);
  localparam int SW = $clog2(START_LEN + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [GW-1:0] rr, sel, idx;
  logic hit;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic sed_q, rec_q;
  logic sed_edge, rec_edge;
  assign sed_edge = slv_sed_qvld & ~sed_q;
  assign rec_edge = slv_rec_qvld & ~rec_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign slv_start = state == START;
  // round-robin pick: scan downward so the nearest valid index after rr wins last
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(rr) + k) % NREQ);
      if (req_valid[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
  end
  // next-state, accept strobe and timeout pulse
  always_comb begin
    state_nx = state;
    req_ready = '0;
    timeout = 1'b0;
    unique case (state)
      IDLE: if (en && hit && !rst) begin
        req_ready[sel] = 1'b1;
        state_nx = START;
      end
      START: state_nx = (scnt == SW'(START_LEN - 1)) ? WAIT : START;
      WAIT: if (sed_edge) state_nx = DONE;
        else if (tcnt == TW'(TMO - 1)) begin
          timeout = 1'b1;
          state_nx = IDLE;
        end
      DONE: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // grant capture, enable lag, phase counters and sent-flag history
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= GW'(NREQ - 1);
      grant_id <= '0;
      slv_din <= '0;
      slv_tx_en <= 1'b0;
      slv_rx_en <= 1'b0;
      scnt <= '0;
      tcnt <= '0;
      sed_q <= 1'b0;
    end else begin
      slv_tx_en <= en;
      slv_rx_en <= en;
      sed_q <= slv_sed_qvld;
      if (state == IDLE && state_nx == START) begin
        slv_din <= req_data[sel*DW +: DW];
        grant_id <= sel;
        rr <= sel;
      end
      scnt <= (state == START) ? scnt + 1'b1 : '0;
      tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
    end
  end
  // saturating receive/error counters; uncorrectable wins over corrected
  always_ff @(posedge clk) begin
    rec_q <= rst ? 1'b0 : slv_rec_qvld;
    if (rst || clr_cnt) begin
      rx_cnt <= '0;
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else if (rec_edge) begin
      rx_cnt <= rx_cnt + CNT_W'(rx_cnt != '1);
      err2_cnt <= err2_cnt + CNT_W'(slv_err_mul && err2_cnt != '1);
      err1_cnt <= err1_cnt + CNT_W'(!slv_err_mul && slv_err_one && err1_cnt != '1);
    end
  end
endmodule

// File: tb/tb_spi_dc_tx_sched.sv
// tb_spi_dc_tx_sched: scoreboard bench for the SPI transmit scheduler and status counters
module tb_spi_dc_tx_sched;
  localparam int TMO = 32;
  localparam int CMAX = 15;
  typedef struct {
    int id;
    logic [7:0] d;
    bit to;
  } item_t;
  logic clk = 0, rst, en, sed, rec, err_one, err_mul, clr_cnt;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_data;
  logic slv_tx_en, slv_rx_en, slv_start, busy, done, timeout;
  logic [7:0] slv_din;
  logic [1:0] grant_id;
  logic [3:0] rx_cnt, err1_cnt, err2_cnt;
  logic [7:0] data [4] = '{8'h01, 8'hA5, 8'h3C, 8'hF0};
  item_t exp_q[$];
  item_t it_m;
  int n_tests = 0, n_fail = 0, m_rr = 3, m_rx = 0, m_e1 = 0, m_e2 = 0;
  spi_dc_tx_sched #(.NREQ(4), .DW(8), .START_LEN(2), .TMO(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .slv_tx_en(slv_tx_en), .slv_rx_en(slv_rx_en),
    .slv_start(slv_start), .slv_din(slv_din), .slv_sed_qvld(sed),
    .slv_rec_qvld(rec), .slv_err_one(err_one), .slv_err_mul(err_mul),
    .busy(busy), .grant_id(grant_id), .done(done), .timeout(timeout),
    .clr_cnt(clr_cnt), .rx_cnt(rx_cnt), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt)
  );
  always #5 clk = ~clk;
  assign req_data = {data[3], data[2], data[1], data[0]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] v, input int rr);
    for (int k = 1; k <= 4; k++)
      if (v[(rr + k) % 4]) return (rr + k) % 4;
    return 0;
  endfunction
  function automatic int sat(input int x);
    return x < CMAX ? x + 1 : CMAX;
  endfunction
  // scoreboard: every done/timeout retires the oldest accepted request
  always @(negedge clk) begin
    if (!rst && (done || timeout)) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        it_m = exp_q.pop_front();
        chk("sb_timeout", 32'(timeout), 32'(it_m.to));
        chk("sb_grant", 32'(grant_id), it_m.id);
        if (!it_m.to) chk("sb_din", 32'(slv_din), 32'(it_m.d));
      end
    end
  end
  // mode 0: sed edge after dly WAIT cycles, 1: timeout, 2: reset during WAIT
  task automatic serve(input logic [3:0] mask, input int dly, input int mode, input bit hold);
    int e, early;
    item_t it;
    req_valid = mask;
    #1;
    e = pick(mask, m_rr);
    chk("ready", 32'(req_ready), 32'(1 << e));
    it.id = e;
    it.d = data[e];
    it.to = (mode == 1);
    exp_q.push_back(it);
    m_rr = e;
    @(negedge clk);
    if (!hold) req_valid = 0;
    chk("ready_pulse", 32'(req_ready), 0);
    chk("start_a", 32'(slv_start), 1);
    chk("din", 32'(slv_din), 32'(data[e]));
    chk("busy", 32'(busy), 1);
    @(negedge clk);
    chk("start_b", 32'(slv_start), 1);
    @(negedge clk);
    chk("start_end", 32'(slv_start), 0);
    if (mode == 0) begin
      repeat (dly) @(negedge clk);
      sed = 1;
      @(negedge clk);
      chk("done", 32'(done), 1);
      sed = 0;
      @(negedge clk);
      chk("done_1cyc", 32'(done), 0);
      chk("idle", 32'(busy), 0);
    end else if (mode == 1) begin
      early = (timeout || done) ? 1 : 0;
      repeat (TMO - 2) begin
        @(negedge clk);
        if (timeout || done) early++;
      end
      chk("no_early_end", early, 0);
      @(negedge clk);
      chk("timeout", 32'(timeout), 1);
      chk("to_nodone", 32'(done), 0);
      @(negedge clk);
      chk("to_idle", 32'(busy), 0);
      chk("to_1cyc", 32'(timeout), 0);
    end else begin
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(slv_start), 0);
      chk("rst_din", 32'(slv_din), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_txen", 32'(slv_tx_en), 0);
      chk("rst_done_to", 32'({done, timeout}), 0);
      void'(exp_q.pop_back());
      rst = 0;
      m_rr = 3;
    end
  endtask
  task automatic rec_ev(input bit one, input bit mul, input bit clr);
    err_one = one;
    err_mul = mul;
    clr_cnt = clr;
    rec = 1;
    @(negedge clk);
    rec = 0;
    err_one = 0;
    err_mul = 0;
    clr_cnt = 0;
    if (clr) begin
      m_rx = 0;
      m_e1 = 0;
      m_e2 = 0;
    end else begin
      m_rx = sat(m_rx);
      if (mul) m_e2 = sat(m_e2);
      else if (one) m_e1 = sat(m_e1);
    end
    @(negedge clk);
    chk("rx_cnt", 32'(rx_cnt), m_rx);
    chk("err1_cnt", 32'(err1_cnt), m_e1);
    chk("err2_cnt", 32'(err2_cnt), m_e2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1; en = 0; sed = 0; rec = 0; err_one = 0; err_mul = 0; clr_cnt = 0; req_valid = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy, slv_start, done, timeout, slv_tx_en, slv_rx_en, req_ready}), 0);
    chk("reset_data", 32'({slv_din, grant_id}), 0);
    chk("reset_cnts", 32'({rx_cnt, err1_cnt, err2_cnt}), 0);
    rst = 0;
    req_valid = 4'b0001;
    #1;
    chk("en_off_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("en_off_busy", 32'(busy), 0);
    req_valid = 0;
    en = 1;
    #1;
    chk("en_lag", 32'(slv_tx_en), 0);
    @(negedge clk);
    chk("en_txrx", 32'({slv_tx_en, slv_rx_en}), 32'(2'b11));
    serve(4'b0001, 18, 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_rr = 3;
    for (int i = 0; i < 5; i++) serve(4'b1111, 3, 0, 1);
    req_valid = 0;
    @(negedge clk);
    serve(4'b0100, TMO - 1, 0, 0);
    serve(4'b0100, 0, 1, 0);
    serve(4'b0010, 0, 2, 0);
    serve(4'b1001, 3, 0, 0);
    serve(4'b1000, 3, 0, 0);
    for (int i = 0; i < 3; i++) rec_ev(1, 0, 0);
    for (int i = 0; i < 2; i++) rec_ev(0, 1, 0);
    rec_ev(1, 1, 0);
    rec_ev(1, 0, 1);
    for (int i = 0; i < 20; i++) rec_ev(1, 0, 0);
    chk("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
